msrv32_decode_stage: RTL and testbench

Registered instruction-decode stage of the msrv32 multi-stage RV32I pipeline. Accepts a fetched instruction and PC over a valid/ready handshake and decodes it into register addresses, immediate, operand selects, control flags and the 4-bit ALU opcode. The ALU opcode is the same encoding the ALU consumes. Results are held in a one-deep pipeline register feeding the execute stage, with stall (back-pressure) and flush support.

---
 rtl/msrv32_pkg.sv | 63 ++++++
 rtl/msrv32_imm_gen.sv | 24 ++
 rtl/msrv32_decode_stage.sv | 185 ++++++++++++++++++
 tb/tb_msrv32_decode_stage.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_pkg.sv
// Shared msrv32 definitions: ALU operation codes, RV32I major opcodes,
// operand-select encodings and the decoded bundle carried by the decode stage.
package msrv32_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [1:0] OP1_RS1  = 2'b00;
    localparam logic [1:0] OP1_PC   = 2'b01;
    localparam logic [1:0] OP1_ZERO = 2'b10;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_SH
    } imm_sel_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  alu;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [1:0]  op1_sel;
        logic        op2_sel;
        logic [2:0]  funct3;
        logic        wb_en;
        logic        mem_rd;
        logic        mem_wr;
        logic        branch;
        logic        jump;
        logic        illegal;
    } decode_t;

    // funct7 must be all-zero; the alternate 0100000 form only where SUB/SRA exist.
    function automatic logic funct7_ok(input logic [6:0] funct7, input logic allow_alt);
        return (funct7 == 7'b0000000) || (allow_alt && funct7 == 7'b0100000);
    endfunction

endpackage

// File: rtl/msrv32_imm_gen.sv
// Combinational RV32I immediate generator: I/S/B/U/J formats plus the
// zero-extended shift amount, selected by the decoder.
module msrv32_imm_gen
    import msrv32_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_sel_e    imm_sel,
    output logic [31:0] imm
);

    always_comb begin
        imm = 32'd0;
        case (imm_sel)
            IMM_I:  imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:  imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:  imm = {instr[31:12], 12'd0};
            IMM_J:  imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_SH: imm = {27'd0, instr[24:20]};
            default: imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/msrv32_decode_stage.sv
// msrv32 instruction-decode stage: decodes a fetched RV32I instruction and
// holds the result in a one-deep valid/ready pipeline register with flush.
module msrv32_decode_stage
    import msrv32_pkg::*;
(
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_n_in,
    input  logic        valid_in,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    output logic        ready_out,
    input  logic        flush_in,
    input  logic        ready_in,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [3:0]  alu_opcode_out,
    output logic [4:0]  rs1_addr_out,
    output logic [4:0]  rs2_addr_out,
    output logic [4:0]  rd_addr_out,
    output logic [31:0] imm_out,
    output logic [1:0]  op1_sel_out,
    output logic        op2_sel_out,
    output logic [2:0]  funct3_out,
    output logic        wb_en_out,
    output logic        mem_rd_out,
    output logic        mem_wr_out,
    output logic        branch_out,
    output logic        jump_out,
    output logic        illegal_out
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    imm_sel_e    imm_sel;
    logic [31:0] imm_d;
    decode_t     dec_d;
    decode_t     dec_q;
    decode_t     bundle_p0;
    logic        vld_p0;
    logic        load;

    assign opcode = instr_in[6:0];
    assign funct3 = instr_in[14:12];
    assign funct7 = instr_in[31:25];

    msrv32_imm_gen u_imm_gen (
        .instr   (instr_in[31:7]),
        .imm_sel (imm_sel),
        .imm     (imm_d)
    );

    always_comb begin
        dec_d         = '0;
        imm_sel       = IMM_NONE;
        dec_d.pc      = pc_in;
        dec_d.funct3  = funct3;
        dec_d.rs1     = instr_in[19:15];
        dec_d.rs2     = instr_in[24:20];
        dec_d.rd      = instr_in[11:7];
        dec_d.alu     = ALU_ADD;
        dec_d.op1_sel = OP1_RS1;
        case (opcode)
            OPC_OP: begin
                dec_d.alu     = {instr_in[30], funct3};
                dec_d.wb_en   = 1'b1;
                dec_d.illegal = !funct7_ok(funct7, (funct3 == 3'b000) || (funct3 == 3'b101));
            end
            OPC_OP_IMM: begin
                dec_d.op2_sel = 1'b1;
                dec_d.wb_en   = 1'b1;
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    imm_sel       = IMM_SH;
                    dec_d.alu     = {funct3[2] & instr_in[30], funct3};
                    dec_d.illegal = !funct7_ok(funct7, funct3[2]);
                end else begin
                    imm_sel   = IMM_I;
                    dec_d.alu = {1'b0, funct3};
                end
            end
            OPC_LOAD: begin
                imm_sel       = IMM_I;
                dec_d.op2_sel = 1'b1;
                dec_d.mem_rd  = 1'b1;
                dec_d.wb_en   = 1'b1;
            end
            OPC_STORE: begin
                imm_sel       = IMM_S;
                dec_d.op2_sel = 1'b1;
                dec_d.mem_wr  = 1'b1;
            end
            OPC_BRANCH: begin
                imm_sel      = IMM_B;
                dec_d.branch = 1'b1;
                case (funct3[2:1])
                    2'b10:   dec_d.alu = ALU_SLT;
                    2'b11:   dec_d.alu = ALU_SLTU;
                    default: dec_d.alu = ALU_SUB;
                endcase
            end
            OPC_JAL: begin
                imm_sel       = IMM_J;
                dec_d.jump    = 1'b1;
                dec_d.op1_sel = OP1_PC;
                dec_d.op2_sel = 1'b1;
                dec_d.wb_en   = 1'b1;
            end
            OPC_JALR: begin
                imm_sel       = IMM_I;
                dec_d.jump    = 1'b1;
                dec_d.op2_sel = 1'b1;
                dec_d.wb_en   = 1'b1;
            end
            OPC_LUI: begin
                imm_sel       = IMM_U;
                dec_d.op1_sel = OP1_ZERO;
                dec_d.op2_sel = 1'b1;
                dec_d.wb_en   = 1'b1;
            end
            OPC_AUIPC: begin
                imm_sel       = IMM_U;
                dec_d.op1_sel = OP1_PC;
                dec_d.op2_sel = 1'b1;
                dec_d.wb_en   = 1'b1;
            end
            default: dec_d.illegal = 1'b1;
        endcase
        // Illegal words still flow downstream as a harmless ADD so execute can trap.
        if (dec_d.illegal) begin
            imm_sel       = IMM_NONE;
            dec_d.alu     = ALU_ADD;
            dec_d.op1_sel = OP1_RS1;
            dec_d.op2_sel = 1'b0;
            dec_d.wb_en   = 1'b0;
            dec_d.mem_rd  = 1'b0;
            dec_d.mem_wr  = 1'b0;
            dec_d.branch  = 1'b0;
            dec_d.jump    = 1'b0;
        end
        if (dec_d.rd == 5'd0) begin
            dec_d.wb_en = 1'b0;
        end
    end

    always_comb begin
        dec_q     = dec_d;
        dec_q.imm = imm_d;
    end

    assign ready_out = !vld_p0 || ready_in;
    assign load      = valid_in && ready_out && !flush_in;

    // Stage p0: decode register feeding execute
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            vld_p0    <= 1'b0;
            bundle_p0 <= '0;
        end else if (flush_in) begin
            vld_p0 <= 1'b0;
        end else if (load) begin
            vld_p0    <= 1'b1;
            bundle_p0 <= dec_q;
        end else if (ready_in) begin
            vld_p0 <= 1'b0;
        end
    end

    assign valid_out      = vld_p0;
    assign pc_out         = bundle_p0.pc;
    assign alu_opcode_out = bundle_p0.alu;
    assign rs1_addr_out   = bundle_p0.rs1;
    assign rs2_addr_out   = bundle_p0.rs2;
    assign rd_addr_out    = bundle_p0.rd;
    assign imm_out        = bundle_p0.imm;
    assign op1_sel_out    = bundle_p0.op1_sel;
    assign op2_sel_out    = bundle_p0.op2_sel;
    assign funct3_out     = bundle_p0.funct3;
    assign wb_en_out      = bundle_p0.wb_en;
    assign mem_rd_out     = bundle_p0.mem_rd;
    assign mem_wr_out     = bundle_p0.mem_wr;
    assign branch_out     = bundle_p0.branch;
    assign jump_out       = bundle_p0.jump;
    assign illegal_out    = bundle_p0.illegal;

endmodule

// File: tb/tb_msrv32_decode_stage.sv
// Scoreboard bench for msrv32_decode_stage: directed cases plus randomized
// traffic checked against a mnemonic-level RV32I decode model.
module tb_msrv32_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] instr_in = 32'd0;
    logic [31:0] pc_in = 32'd0;
    logic        ready_out;
    logic        flush_in = 1'b0;
    logic        ready_in = 1'b0;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [3:0]  alu_opcode_out;
    logic [4:0]  rs1_addr_out, rs2_addr_out, rd_addr_out;
    logic [31:0] imm_out;
    logic [1:0]  op1_sel_out;
    logic        op2_sel_out;
    logic [2:0]  funct3_out;
    logic        wb_en_out, mem_rd_out, mem_wr_out, branch_out, jump_out, illegal_out;

    msrv32_decode_stage dut (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_n_in (rst_n),
        .valid_in               (valid_in),
        .instr_in               (instr_in),
        .pc_in                  (pc_in),
        .ready_out              (ready_out),
        .flush_in               (flush_in),
        .ready_in               (ready_in),
        .valid_out              (valid_out),
        .pc_out                 (pc_out),
        .alu_opcode_out         (alu_opcode_out),
        .rs1_addr_out           (rs1_addr_out),
        .rs2_addr_out           (rs2_addr_out),
        .rd_addr_out            (rd_addr_out),
        .imm_out                (imm_out),
        .op1_sel_out            (op1_sel_out),
        .op2_sel_out            (op2_sel_out),
        .funct3_out             (funct3_out),
        .wb_en_out              (wb_en_out),
        .mem_rd_out             (mem_rd_out),
        .mem_wr_out             (mem_wr_out),
        .branch_out             (branch_out),
        .jump_out               (jump_out),
        .illegal_out            (illegal_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  alu;
        logic [31:0] imm;
        logic [1:0]  op1;
        logic        op2;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        wb;
        logic        mrd;
        logic        mwr;
        logic        br;
        logic        jmp;
        logic        ill;
    } exp_t;

    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    endtask

    function automatic logic [3:0] alu_code(input string mn);
        case (mn)
            "ADD":   return 4'b0000;
            "SUB":   return 4'b1000;
            "SLL":   return 4'b0001;
            "SLT":   return 4'b0010;
            "SLTU":  return 4'b0011;
            "XOR":   return 4'b0100;
            "SRL":   return 4'b0101;
            "SRA":   return 4'b1101;
            "OR":    return 4'b0110;
            "AND":   return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    // Reference decode: choose the mnemonic and operand shape, then look up the code.
    function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
        exp_t  e;
        string base_ops[8];
        string mn;
        logic [2:0] f3;
        logic [6:0] f7;
        base_ops = '{"ADD", "SLL", "SLT", "SLTU", "XOR", "SRL", "OR", "AND"};
        f3 = w[14:12];
        f7 = w[31:25];
        e = '0;
        mn = "ADD";
        e.f3 = f3; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; e.pc = pc;
        case (w[6:0])
            7'b0110011: begin
                e.wb = 1;
                if (f7 == 7'h00) mn = base_ops[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) mn = "SUB";
                else if (f7 == 7'h20 && f3 == 3'd5) mn = "SRA";
                else e.ill = 1;
            end
            7'b0010011: begin
                e.wb = 1; e.op2 = 1;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.imm = {27'd0, w[24:20]};
                    if (f7 == 7'h00) mn = base_ops[f3];
                    else if (f7 == 7'h20 && f3 == 3'd5) mn = "SRA";
                    else e.ill = 1;
                end else begin
                    e.imm = 32'($signed(w[31:20]));
                    mn = base_ops[f3];
                end
            end
            7'b0000011: begin e.wb = 1; e.op2 = 1; e.mrd = 1; e.imm = 32'($signed(w[31:20])); end
            7'b0100011: begin e.op2 = 1; e.mwr = 1; e.imm = 32'($signed({w[31:25], w[11:7]})); end
            7'b1100011: begin
                e.br = 1;
                e.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
                if (f3 == 3'd4 || f3 == 3'd5) mn = "SLT";
                else if (f3 == 3'd6 || f3 == 3'd7) mn = "SLTU";
                else mn = "SUB";
            end
            7'b1101111: begin
                e.wb = 1; e.jmp = 1; e.op1 = 2'b01; e.op2 = 1;
                e.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
            end
            7'b1100111: begin e.wb = 1; e.jmp = 1; e.op2 = 1; e.imm = 32'($signed(w[31:20])); end
            7'b0110111: begin e.wb = 1; e.op1 = 2'b10; e.op2 = 1; e.imm = {w[31:12], 12'd0}; end
            7'b0010111: begin e.wb = 1; e.op1 = 2'b01; e.op2 = 1; e.imm = {w[31:12], 12'd0}; end
            default: e.ill = 1;
        endcase
        if (e.ill) begin
            mn = "ADD";
            e.wb = 0; e.mrd = 0; e.mwr = 0; e.br = 0; e.jmp = 0;
        end
        if (e.rd == 5'd0) e.wb = 0;
        e.alu = alu_code(mn);
        return e;
    endfunction

    // imm/operand selects of an illegal word carry no meaning and are not compared.
    function automatic exp_t mask(input exp_t e);
        exp_t m;
        m = e;
        if (e.ill) begin m.imm = '0; m.op1 = '0; m.op2 = 1'b0; end
        return m;
    endfunction

    function automatic exp_t dut_bundle();
        exp_t a;
        a.alu = alu_opcode_out; a.imm = imm_out; a.op1 = op1_sel_out; a.op2 = op2_sel_out;
        a.f3 = funct3_out; a.rs1 = rs1_addr_out; a.rs2 = rs2_addr_out; a.rd = rd_addr_out;
        a.pc = pc_out; a.wb = wb_en_out; a.mrd = mem_rd_out; a.mwr = mem_wr_out;
        a.br = branch_out; a.jmp = jump_out; a.ill = illegal_out;
        return a;
    endfunction

    // Monitor: inputs are stable between posedge+1 and the next posedge.
    bit   mon_busy, mon_rdy;
    exp_t mon_act, mon_exp;
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            mon_busy = (sb_q.size() != 0);
            mon_rdy  = !mon_busy || ready_in;
            chk("valid_out", 128'(valid_out), 128'(mon_busy));
            chk("ready_out", 128'(ready_out), 128'(mon_rdy));
            if (valid_out && mon_busy) begin
                mon_act = dut_bundle();
                if (sb_q[0].ill) mon_act.ill = 1'b1;
                mon_act = mask(dut_bundle());
                mon_exp = mask(sb_q[0]);
                if (sb_q[0].ill && !illegal_out) mon_act = dut_bundle();
                chk("bundle", 128'(mon_act), 128'(mon_exp));
            end
            if (flush_in) begin
                sb_q.delete();
            end else begin
                if (mon_busy && ready_in) void'(sb_q.pop_front());
                if (valid_in && mon_rdy) sb_q.push_back(model(instr_in, pc_in));
            end
        end
    end

    task automatic issue(input logic [31:0] w, input logic [31:0] pc);
        @(posedge clk); #1;
        valid_in = 1'b1; instr_in = w; pc_in = pc; ready_in = 1'b1; flush_in = 1'b0;
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    function automatic logic [6:0] pick_f7();
        int r;
        r = $urandom_range(0, 4);
        if (r < 2) return 7'h00;
        if (r < 4) return 7'h20;
        return 7'($urandom);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 11);
        case (k)
            0: begin w[6:0] = 7'b0110011; w[31:25] = pick_f7(); end
            1: begin w[6:0] = 7'b0010011; if (w[13:12] == 2'b01) w[31:25] = pick_f7(); end
            2: w[6:0] = 7'b0000011;
            3: w[6:0] = 7'b0100011;
            4: begin w[6:0] = 7'b1100011; if (w[14:13] == 2'b01) w[14] = 1'b1; end
            5: w[6:0] = 7'b1101111;
            6: w[6:0] = 7'b1100111;
            7: w[6:0] = 7'b0110111;
            8: w[6:0] = 7'b0010111;
            9: w[6:0] = 7'b0001111;
            10: w[6:0] = 7'b1110011;
            default: ;
        endcase
        if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
        return w;
    endfunction

    logic [127:0] snap;
    logic [127:0] all_out;
    assign all_out = {valid_out, pc_out, alu_opcode_out, rs1_addr_out, rs2_addr_out, rd_addr_out,
                      imm_out, op1_sel_out, op2_sel_out, funct3_out, wb_en_out, mem_rd_out,
                      mem_wr_out, branch_out, jump_out, illegal_out};

    initial begin
        #3;
        chk("reset_outputs", all_out, 128'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        issue(32'hFFF00093, 32'h100);
        chk("addi_alu", 128'(alu_opcode_out), 128'(4'b0000));
        chk("addi_imm", 128'(imm_out), 128'(32'hFFFFFFFF));
        chk("addi_op2", 128'(op2_sel_out), 128'(1'b1));
        chk("addi_wb", 128'(wb_en_out), 128'(1'b1));
        chk("addi_rd", 128'(rd_addr_out), 128'(5'd1));

        issue(32'h40315093, 32'h104);
        chk("srai_alu", 128'(alu_opcode_out), 128'(4'b1101));
        chk("srai_imm", 128'(imm_out), 128'(32'h3));
        chk("srai_rs1", 128'(rs1_addr_out), 128'(5'd2));

        issue(32'h402081B3, 32'h108);
        chk("sub_alu", 128'(alu_opcode_out), 128'(4'b1000));
        chk("sub_op2", 128'(op2_sel_out), 128'(1'b0));

        issue(32'h0020E463, 32'h10C);
        chk("bltu_alu", 128'(alu_opcode_out), 128'(4'b0011));
        chk("bltu_branch", 128'(branch_out), 128'(1'b1));
        chk("bltu_imm", 128'(imm_out), 128'(32'h8));
        chk("bltu_wb", 128'(wb_en_out), 128'(1'b0));

        issue(32'h123452B7, 32'h110);
        chk("lui_op1", 128'(op1_sel_out), 128'(2'b10));
        chk("lui_imm", 128'(imm_out), 128'(32'h12345000));
        chk("lui_alu", 128'(alu_opcode_out), 128'(4'b0000));

        // Stall: hold ready_in low with a different word pending on the input.
        issue(32'h402081B3, 32'h200);
        ready_in = 1'b0; valid_in = 1'b1; instr_in = 32'hFFF00093; pc_in = 32'h204;
        snap = all_out;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_stable", all_out, snap);
            chk("stall_ready", 128'(ready_out), 128'(1'b0));
        end
        flush_in = 1'b1;
        @(posedge clk); #1;
        flush_in = 1'b0; valid_in = 1'b0;
        chk("flush_valid", 128'(valid_out), 128'(1'b0));

        issue(32'h00000000, 32'h300);
        chk("illegal_flag", 128'(illegal_out), 128'(1'b1));
        chk("illegal_valid", 128'(valid_out), 128'(1'b1));
        chk("illegal_wb", 128'(wb_en_out), 128'(1'b0));

        // Reset arriving while a bundle is stalled.
        issue(32'hFFF00093, 32'h400);
        ready_in = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("reset_midstall", all_out, 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            valid_in = ($urandom_range(0, 9) < 7);
            instr_in = rand_instr();
            pc_in    = $urandom & 32'hFFFF_FFFC;
            flush_in = ($urandom_range(0, 19) == 0);
            ready_in = flush_in ? 1'b0 : ($urandom_range(0, 9) < 7);
        end
        @(posedge clk); #1;
        valid_in = 1'b0; flush_in = 1'b0; ready_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("drained", 128'(sb_q.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
